// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch unit, the prefetch
// queue and the decode stage.
//   Flush                 redirect: discard every buffered entry
//   InValid/InPC/InInstr  fetch -> queue pair, with InReady back-pressure
//   OutValid/OutPC/OutInstr queue -> decode head entry, with OutReady consume
//   Count                 number of stored entries, 0..DEPTH
// modport slave is the queue side, modport master is the fetch/decode side.
interface fetch_queue_if #(
    parameter int AW = 2
);
    logic          Flush;
    logic          InValid;
    logic [31:0]   InPC;
    logic [31:0]   InInstr;
    logic          InReady;
    logic          OutValid;
    logic [31:0]   OutPC;
    logic [31:0]   OutInstr;
    logic          OutReady;
    logic [AW:0]   Count;

    modport master (
        output Flush, InValid, InPC, InInstr, OutReady,
        input  InReady, OutValid, OutPC, OutInstr, Count
    );

    modport slave (
        input  Flush, InValid, InPC, InInstr, OutReady,
        output InReady, OutValid, OutPC, OutInstr, Count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer. {PC, Instr} pairs from fetch are
// held in a DEPTH-entry circular FIFO and handed to decode in order. Flush
// empties the queue on a control-flow redirect.
//   Clk    system clock, rising edge
//   Reset  synchronous active-low reset (0 = reset); clears pointers, count
//          and storage, and wins over Flush and any handshake
//   q      fetch_queue_if.slave: Flush, In* (enqueue side), Out* (dequeue
//          side), Count
// Build option FETCH_QUEUE_BYPASS_EN: when the queue is empty and not
// flushing, the fetch pair is visible at the outputs in the same cycle and
// is consumed without being written if decode is ready. Without it there is
// no combinational input-to-output path and minimum latency is one cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    fetch_queue_if.slave   q
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic          not_full;
    logic          not_empty;
    logic          enq;
    logic          deq;
    logic [63:0]   head_word;

    assign not_full  = (count != FULL_CNT);
    assign not_empty = (count != '0);
    assign head_word = mem[head];

    // Ready never looks at OutReady, so fetch cannot see a decode-to-fetch
    // combinational path.
    assign q.InReady = not_full && !q.Flush;
    assign q.Count   = count;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass     = !not_empty && !q.Flush;
    assign q.OutValid = bypass ? q.InValid : (not_empty && !q.Flush);
    assign q.OutPC    = bypass ? q.InPC    : head_word[63:32];
    assign q.OutInstr = bypass ? q.InInstr : head_word[31:0];
    // In bypass the pair is either taken straight by decode (no write)
    // or, if decode stalls, stored like any other enqueue.
    assign deq = q.OutValid && q.OutReady && !bypass;
    assign enq = q.InValid && q.InReady && !(bypass && q.OutReady);
`else
    assign q.OutValid = not_empty && !q.Flush;
    assign q.OutPC    = head_word[63:32];
    assign q.OutInstr = head_word[31:0];
    assign deq = q.OutValid && q.OutReady;
    assign enq = q.InValid && q.InReady;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (q.Flush) begin
            // Storage is left as-is; only the bookkeeping is dropped.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                mem[tail] <= {q.InPC, q.InInstr};
                tail      <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
